// File: rtl/noc_flit_pkg.sv
// Shared flit field layout, sizing functions and FSM state type for the NoC packetizer.
package noc_flit_pkg;

  // Field offsets counted down from the flit MSB; the destination sits DEST_POS+vc_width below it.
  localparam int VALID_POS = 0;
  localparam int HEAD_POS  = 1;
  localparam int TAIL_POS  = 2;
  localparam int VC_POS    = 3;
  localparam int DEST_POS  = 3;
  localparam int VC_MAX_W  = 8;

  typedef struct packed {
    logic                valid;
    logic                head;
    logic                tail;
    logic [VC_MAX_W-1:0] vc;
  } flit_hdr_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } pkt_state_t;

  function automatic int calc_hp(int w_noc, int vcw, int aw);
    return w_noc - 3 - vcw - aw;
  endfunction

  function automatic int calc_bp(int w_noc, int vcw);
    return w_noc - 3 - vcw;
  endfunction

  function automatic int calc_num_flits(int w_data, int hp, int bp);
    int extra;
    extra = (w_data > hp) ? (w_data - hp) : 0;
    return 1 + (extra + bp - 1) / bp;
  endfunction

  function automatic int calc_num_beats(int num_flits);
    return (num_flits + 3) / 4;
  endfunction

endpackage

// File: rtl/flit_slicer.sv
// Combinational slicer: lays a transaction out as a flit frame and selects one beat of it.
module flit_slicer
  import noc_flit_pkg::*;
#(
  parameter int WIDTH_NOC  = 128,
  parameter int WIDTH_RTL  = 512,
  parameter int WIDTH_DATA = 600,
  parameter int AW         = 4,
  parameter int VCW        = 1,
  parameter int HP         = 120,
  parameter int BP         = 124,
  parameter int NUM_FLITS  = 5,
  parameter int NUM_BEATS  = 2,
  parameter int BIW        = 1
) (
  input  logic [WIDTH_DATA-1:0] data,
  input  logic [AW-1:0]         dest,
  input  logic [VCW-1:0]        vc,
  input  logic [BIW-1:0]        beat_idx,
  output logic [WIDTH_RTL-1:0]  beat
);

  localparam int PADW = HP + (NUM_FLITS - 1) * BP;
  localparam int TOTW = NUM_BEATS * WIDTH_RTL;

  logic [PADW-1:0]      padded;
  logic [TOTW-1:0]      frame;
  logic [WIDTH_NOC-1:0] flit;
  flit_hdr_t            hdr;
  int                   base;

  // Payload is left-aligned so the last flit picks up the zero padding.
  always_comb begin
    padded = '0;
    padded[PADW-1 -: WIDTH_DATA] = data;
  end

  always_comb begin
    frame = '0;
    flit  = '0;
    hdr   = '0;
    base  = 0;
    for (int k = 0; k < NUM_FLITS; k++) begin
      hdr       = '0;
      hdr.valid = 1'b1;
      hdr.head  = (k == 0);
      hdr.tail  = (k == NUM_FLITS - 1);
      hdr.vc    = VC_MAX_W'(vc);
      flit      = '0;
      flit[WIDTH_NOC-1-VALID_POS]      = hdr.valid;
      flit[WIDTH_NOC-1-HEAD_POS]       = hdr.head;
      flit[WIDTH_NOC-1-TAIL_POS]       = hdr.tail;
      flit[WIDTH_NOC-1-VC_POS -: VCW]  = hdr.vc[VCW-1:0];
      if (k == 0) begin
        flit[WIDTH_NOC-1-DEST_POS-VCW -: AW] = dest;
        flit[HP-1:0] = padded[PADW-1 -: HP];
      end else begin
        base = PADW - 1 - HP - (k - 1) * BP;
        flit[BP-1:0] = padded[base -: BP];
      end
      frame[TOTW-1-k*WIDTH_NOC -: WIDTH_NOC] = flit;
    end
  end

  assign beat = frame[TOTW-1-int'(beat_idx)*WIDTH_RTL -: WIDTH_RTL];

endmodule

// File: rtl/noc_packetizer.sv
// Accepts one wide user transaction and streams it as four-flit beats to the fabric interface.
// state   | meaning
// IDLE    | no packet in flight, ready for a transaction
// SEND    | beat beat_idx on o_packet_out, waiting for o_ready_in
module noc_packetizer
  import noc_flit_pkg::*;
#(
  parameter int WIDTH_NOC  = 128,
  parameter int WIDTH_RTL  = 512,
  parameter int N          = 16,
  parameter int NUM_VC     = 2,
  parameter int WIDTH_DATA = 600
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH_DATA-1:0]        i_data_in,
  input  logic [$clog2(N)-1:0]         i_dest_in,
  input  logic [$clog2(NUM_VC)-1:0]    i_vc_in,
  input  logic                         i_valid_in,
  output logic                         i_ready_out,
  output logic [WIDTH_RTL-1:0]         o_packet_out,
  output logic                         o_valid_out,
  input  logic                         o_ready_in
);

  localparam int ADDRESS_WIDTH    = $clog2(N);
  localparam int VC_ADDRESS_WIDTH = $clog2(NUM_VC);
  localparam int HP        = calc_hp(WIDTH_NOC, VC_ADDRESS_WIDTH, ADDRESS_WIDTH);
  localparam int BP        = calc_bp(WIDTH_NOC, VC_ADDRESS_WIDTH);
  localparam int NUM_FLITS = calc_num_flits(WIDTH_DATA, HP, BP);
  localparam int NUM_BEATS = calc_num_beats(NUM_FLITS);
  localparam int BIW       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BIW-1:0] LAST_BEAT = BIW'(NUM_BEATS - 1);

  if (NUM_FLITS > 16 || WIDTH_RTL != 4 * WIDTH_NOC) begin : g_param_check
    $error("noc_packetizer: unsupported flit count or beat width");
  end

  pkt_state_t                    state, state_d;
  logic [BIW-1:0]                beat_idx, beat_d;
  logic                          valid_d, load, accept;
  logic [WIDTH_DATA-1:0]         data_q, sel_data;
  logic [ADDRESS_WIDTH-1:0]      dest_q, sel_dest;
  logic [VC_ADDRESS_WIDTH-1:0]   vc_q, sel_vc;
  logic [WIDTH_RTL-1:0]          beat_w;

  assign i_ready_out = !rst && (state == ST_IDLE || (beat_idx == LAST_BEAT && o_ready_in));
  assign accept      = i_valid_in && i_ready_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      beat_idx    <= '0;
      o_valid_out <= 1'b0;
    end else begin
      state       <= state_d;
      beat_idx    <= beat_d;
      o_valid_out <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    beat_d  = beat_idx;
    valid_d = o_valid_out;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SEND;
          beat_d  = '0;
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        if (o_ready_in) begin
          if (beat_idx != LAST_BEAT) begin
            beat_d = beat_idx + 1'b1;
            load   = 1'b1;
          end else if (accept) begin
            beat_d = '0;
            load   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            beat_d  = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The slicer sees the values the registers are about to take, so the beat register loads in step.
  assign sel_data = accept ? i_data_in : data_q;
  assign sel_dest = accept ? i_dest_in : dest_q;
  assign sel_vc   = accept ? i_vc_in   : vc_q;

  flit_slicer #(
    .WIDTH_NOC (WIDTH_NOC),
    .WIDTH_RTL (WIDTH_RTL),
    .WIDTH_DATA(WIDTH_DATA),
    .AW        (ADDRESS_WIDTH),
    .VCW       (VC_ADDRESS_WIDTH),
    .HP        (HP),
    .BP        (BP),
    .NUM_FLITS (NUM_FLITS),
    .NUM_BEATS (NUM_BEATS),
    .BIW       (BIW)
  ) u_slicer (
    .data    (sel_data),
    .dest    (sel_dest),
    .vc      (sel_vc),
    .beat_idx(beat_d),
    .beat    (beat_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q       <= '0;
      dest_q       <= '0;
      vc_q         <= '0;
      o_packet_out <= '0;
    end else begin
      if (accept) begin
        data_q <= i_data_in;
        dest_q <= i_dest_in;
        vc_q   <= i_vc_in;
      end
      if (load) o_packet_out <= beat_w;
    end
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// Randomized scoreboard bench for noc_packetizer plus a few hand-computed beats.
module tb_noc_packetizer;

  localparam int HP_M = 128 - 3 - 1 - 4;
  localparam int BP_M = 128 - 3 - 1;
  localparam int NF_M = 1 + (600 - HP_M + BP_M - 1) / BP_M;
  localparam int NB_M = (NF_M + 3) / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [599:0] data_in = '0;
  logic [3:0]   dest_in = '0;
  logic         vc_in = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_out;
  logic [511:0] pkt;
  logic         valid_out;
  logic         ready_in = 1'b0;

  logic [99:0]  data_s = '0;
  logic [3:0]   dest_s = '0;
  logic         vc_s = 1'b0;
  logic         valid_s = 1'b0;
  logic         ready_out_s;
  logic [511:0] pkt_s;
  logic         valid_out_s;
  logic         ready_in_s = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  logic [511:0] exp_q[$];
  logic         prev_stall = 1'b0;
  logic [511:0] prev_pkt = '0;

  always #5 clk = ~clk;

  noc_packetizer dut (
    .clk(clk), .rst(rst), .i_data_in(data_in), .i_dest_in(dest_in), .i_vc_in(vc_in),
    .i_valid_in(valid_in), .i_ready_out(ready_out), .o_packet_out(pkt),
    .o_valid_out(valid_out), .o_ready_in(ready_in)
  );

  noc_packetizer #(.WIDTH_DATA(100)) dut_s (
    .clk(clk), .rst(rst), .i_data_in(data_s), .i_dest_in(dest_s), .i_vc_in(vc_s),
    .i_valid_in(valid_s), .i_ready_out(ready_out_s), .o_packet_out(pkt_s),
    .o_valid_out(valid_out_s), .o_ready_in(ready_in_s)
  );

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference: payload as a bit stream, popped head-first into flits, flits dealt four per beat.
  function automatic logic [511:0] model_beat(logic [599:0] d, logic [3:0] dest, logic vc, int b);
    bit           bq[$];
    logic [127:0] fl;
    logic [511:0] r;
    int           cap;
    r = '0;
    for (int i = 599; i >= 0; i--) bq.push_back(d[i]);
    for (int k = 0; k < NF_M; k++) begin
      fl = '0;
      fl[127] = 1'b1;
      fl[126] = (k == 0);
      fl[125] = (k == NF_M - 1);
      fl[124] = vc;
      if (k == 0) fl[123:120] = dest;
      cap = (k == 0) ? HP_M : BP_M;
      for (int j = cap - 1; j >= 0; j--) fl[j] = (bq.size() > 0) ? bq.pop_front() : 1'b0;
      if (k / 4 == b) r[511-128*(k%4) -: 128] = fl;
    end
    return r;
  endfunction

  function automatic logic [599:0] rand600();
    logic [607:0] v;
    for (int i = 0; i < 19; i++) v[32*i +: 32] = $urandom;
    return v[599:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", 512'(valid_out), 512'(0));
      chk("rst_packet", pkt, '0);
      chk("rst_ready", 512'(ready_out), 512'(0));
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("ready_out", 512'(ready_out),
          512'(exp_q.size() == 0 || (exp_q.size() == 1 && ready_in)));
      chk("valid_out", 512'(valid_out), 512'(exp_q.size() > 0));
      if (prev_stall) chk("hold_stable", pkt, prev_pkt);
      if (valid_out && ready_in && exp_q.size() > 0) chk("beat_data", pkt, exp_q.pop_front());
      prev_stall = valid_out && !ready_in;
      prev_pkt   = pkt;
      if (valid_in && ready_out)
        for (int b = 0; b < NB_M; b++) exp_q.push_back(model_beat(data_in, dest_in, vc_in, b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [599:0] d1;
    logic [511:0] m0, m1, exp_s;
    logic [99:0]  d100;
    logic         acc;
    int           n_acc, guard;

    // Model pins against hand-derived flit images.
    d1 = 600'h1;
    m0 = model_beat(d1, 4'd5, 1'b1, 0);
    m1 = model_beat(d1, 4'd5, 1'b1, 1);
    chk("model_b0_hdr", 512'(m0[511:504]), 512'(8'hD5));
    chk("model_b0_s1", 512'(m0[383:380]), 512'(4'h9));
    chk("model_b0_s3", 512'(m0[127:124]), 512'(4'h9));
    chk("model_b1_s0", 512'(m1[511:384]), 512'({4'hB, 107'h0, 1'b1, 16'h0}));
    chk("model_b1_pad", 512'(m1[383:0]), '0);

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single-flit instance: one beat, head and tail both set.
    d100 = 100'hF0123456789ABCDEF01234567;
    chk("s_ready_idle", 512'(ready_out_s), 512'(1));
    data_s = d100; dest_s = 4'd3; vc_s = 1'b0; valid_s = 1'b1; ready_in_s = 1'b1;
    tick();
    valid_s = 1'b0; data_s = '0;
    exp_s = {8'hE3, d100, 20'h0, 384'h0};
    chk("s_valid", 512'(valid_out_s), 512'(1));
    chk("s_beat", pkt_s, exp_s);
    tick();
    chk("s_valid_drop", 512'(valid_out_s), 512'(0));

    // Directed two-beat packet.
    data_in = d1; dest_in = 4'd5; vc_in = 1'b1; valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0; data_in = rand600();
    chk("d_b0_hdr", 512'(pkt[511:504]), 512'(8'hD5));
    tick();
    chk("d_b1_s0", 512'(pkt[511:384]), 512'({4'hB, 107'h0, 1'b1, 16'h0}));
    tick();

    // Backpressure for five cycles on beat 0.
    data_in = rand600(); dest_in = 4'($urandom); vc_in = 1'($urandom); valid_in = 1'b1;
    tick();
    valid_in = 1'b0; ready_in = 1'b0;
    repeat (5) tick();
    ready_in = 1'b1;
    repeat (3) tick();

    // Back-to-back: valid held high across three transactions.
    data_in = rand600(); dest_in = 4'($urandom); vc_in = 1'($urandom); valid_in = 1'b1;
    n_acc = 0; guard = 0;
    while (n_acc < 3 && guard < 50) begin
      @(negedge clk);
      acc = ready_out;
      tick();
      guard++;
      if (acc) begin
        n_acc++;
        data_in = rand600(); dest_in = 4'($urandom); vc_in = 1'($urandom);
      end
    end
    chk("b2b_accepts", 512'(n_acc), 512'(3));
    valid_in = 1'b0;
    repeat (4) tick();

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      valid_in = 1'($urandom_range(0, 1));
      ready_in = ($urandom_range(0, 3) != 0);
      data_in  = rand600();
      dest_in  = 4'($urandom);
      vc_in    = 1'($urandom);
      tick();
    end
    valid_in = 1'b0; ready_in = 1'b1;
    repeat (4) tick();

    // Reset while beat 1 is pending.
    data_in = rand600(); dest_in = 4'd9; vc_in = 1'b0; valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0; ready_in = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 512'(valid_out), 512'(0));
    chk("async_rst_packet", pkt, '0);
    tick();
    rst = 1'b0;
    ready_in = 1'b1;
    tick();
    chk("post_rst_idle", 512'(valid_out), 512'(0));
    data_in = rand600(); dest_in = 4'd2; vc_in = 1'b1; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("post_rst_head", 512'(pkt[510:509]), 512'(2'b10));

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("drain", 512'(exp_q.size()), 512'(0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/noc_packetizer.md
# noc_packetizer

Upstream translator for the fabric interface. It accepts one wide user transaction (payload, destination, VC) per handshake and slices it into NoC flits with valid/head/tail/VC/destination fields. It emits those flits as WIDTH_RTL-wide beats of four flit slots each, in the exact format the fabric interface's input FIFO consumes. A single-clock block, instantiated once per module port in that module's `clk_rtl` domain.

## Interface
- `WIDTH_NOC`, 128: flit width.
- `WIDTH_RTL`, 512: beat width; must equal 4*WIDTH_NOC.
- `N`, 16: node count; ADDRESS_WIDTH = $clog2(N).
- `NUM_VC`, 2: VC count; VC_ADDRESS_WIDTH = $clog2(NUM_VC).
- `WIDTH_DATA`, 600: user payload width.
- `clk`, input, 1: block clock (the module's `clk_rtl`).
- `rst`, input, 1: reset, asynchronous, active-high.
- `i_data_in`, input, WIDTH_DATA: payload.
- `i_dest_in`, input, ADDRESS_WIDTH: destination node.
- `i_vc_in`, input, VC_ADDRESS_WIDTH: VC used for every flit of the packet.
- `i_valid_in`, input, 1: user transaction valid.
- `i_ready_out`, output, 1: block can accept a transaction.
- `o_packet_out`, output, WIDTH_RTL: beat to the fabric interface.
- `o_valid_out`, output, 1: beat valid.
- `o_ready_in`, input, 1: fabric interface ready (its input FIFO ready).

## Operation
- Flit layout, MSB first: bit WIDTH_NOC-1 = valid, WIDTH_NOC-2 = head, WIDTH_NOC-3 = tail, then VC (VC_ADDRESS_WIDTH bits).
  - Head flits add the destination (ADDRESS_WIDTH bits) below the VC, then payload in the remaining low bits.
  - Body and tail flits carry payload directly below the VC.
- Payload capacities: HP = WIDTH_NOC-3-VC_ADDRESS_WIDTH-ADDRESS_WIDTH for the head flit; BP = WIDTH_NOC-3-VC_ADDRESS_WIDTH for other flits.
- Flit count: NUM_FLITS = 1 + ceil(max(0, WIDTH_DATA-HP)/BP). NUM_BEATS = ceil(NUM_FLITS/4).
  - Elaboration error if NUM_FLITS > 16 or WIDTH_RTL != 4*WIDTH_NOC.
- Payload is consumed MSB first. The head flit takes i_data_in[WIDTH_DATA-1 -: HP], and each following flit takes the next BP bits. The last flit is zero-padded at the LSBs.
- Flit k goes to beat k/4, slot k%4. Slot s occupies o_packet_out[WIDTH_RTL-1-WIDTH_NOC*s -: WIDTH_NOC], so slot 0 is the MSBs.
  - Unused slots of the last beat are all-zero (valid=0).
- A single-flit packet sets head=1 and tail=1.
- FSM:
  - IDLE: i_ready_out=1. On i_valid_in && i_ready_out, register the transaction, load beat 0 into o_packet_out, set o_valid_out=1 and beat_idx=0, and go to SEND.
  - SEND: hold the beat stable while o_valid_out && !o_ready_in. On o_ready_in:
    - If beat_idx < NUM_BEATS-1: increment beat_idx and load the next beat.
    - Else (last beat): if i_valid_in, accept the next transaction the same cycle and load its beat 0. Otherwise clear o_valid_out and return to IDLE.
- i_ready_out = !rst && (state==IDLE || (beat_idx==NUM_BEATS-1 && o_ready_in)).
- The registered copy of i_data_in, i_dest_in and i_vc_in is held for the whole packet. User inputs may change after acceptance.
- i_dest_in is not range-checked against N.

## Timing
- Reset values: o_valid_out=0, o_packet_out=0, state=IDLE, beat_idx=0. i_ready_out=0 while rst is high and 1 the first cycle after.
- Latency: a transaction accepted at edge t appears on o_valid_out/o_packet_out after edge t.
- Throughput: one beat per cycle when o_ready_in=1; back-to-back packets with no bubble.
- o_packet_out is fully registered. i_ready_out is combinational from state, beat_idx and o_ready_in.
- o_valid_out never drops and o_packet_out never changes while o_ready_in=0 (AXI-style stability).
- Reset asserted mid-packet discards the remaining beats. No partial tail is emitted after reset.

## Structure
- Package `noc_flit_pkg` holds:
  - position localparams: VALID_POS, HEAD_POS, TAIL_POS, VC_POS, DEST_POS;
  - functions computing HP, BP, NUM_FLITS and NUM_BEATS from the parameters;
  - a `flit_hdr_t` packed struct (valid, head, tail, vc).
- One sub-module, `flit_slicer`: combinational. Inputs are the registered transaction and beat_idx; output is one WIDTH_RTL beat. The FSM and output register stay in `noc_packetizer`.

## Test plan
- Defaults, data=600'h1 pattern, dest=5, vc=1, o_ready_in=1. Expect two beats on consecutive cycles:
  - beat0 slot0[127:120]=0xD5; slots1–2 top nibble 0x9; slot3 top nibble 0x9.
  - beat1 slot0 top nibble 0xB (tail); slots1–3 = 0.
- o_ready_in low for 5 cycles mid-packet: beat0 held bit-exact, i_ready_out=0; beat1 follows the cycle after ready returns.
- Back-to-back: i_valid_in held high with 3 transactions, o_ready_in=1. Expect 6 consecutive valid beats and i_ready_out pulsing on every second beat.
- WIDTH_DATA=100: one beat; slot0 has head=tail=1 and payload left-aligned with zero padding; slots1–3 = 0.
- rst pulse while beat1 is pending: o_valid_out=0 and o_packet_out=0 immediately (async). No beat1 emitted; the next accepted packet starts with a head flit.
